// File: rtl/sm_alu_pkg.sv
// Shared opcode encoding, status bit positions and the flag helper for the SM/U2 ALU.
package sm_alu_pkg;

    typedef enum logic [1:0] {
        OP_SUB     = 2'd0,
        OP_SM_LT   = 2'd1,
        OP_CLR_BIT = 2'd2,
        OP_SM2U2   = 2'd3
    } op_e;

    localparam int ST_ZERO = 0;
    localparam int ST_MSB  = 1;
    localparam int ST_EVEN = 2;
    localparam int ST_ONES = 3;

    // Status flags of a w-bit result held in the low bits of res.
    function automatic logic [3:0] f_status(input logic [63:0] res, input int w);
        logic [63:0] mask;
        logic [63:0] val;
        logic [3:0]  st;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        val  = res & mask;
        st   = '0;
        st[ST_ZERO] = (val == '0);
        st[ST_MSB]  = val[w-1];
        st[ST_EVEN] = ~^val;
        st[ST_ONES] = (val == mask);
        return st;
    endfunction

endpackage

// File: rtl/sm_alu_unit.sv
// Combinational core: opcode and operands to result, status flags and error bit.
module sm_alu_unit
    import sm_alu_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 2
) (
    input  logic [N-1:0] op,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] result,
    output logic [3:0]   status,
    output logic         error
);

    localparam logic [M-1:0] IDX_LIM = M[M-1:0];
    localparam logic [M-1:0] ONE     = {{(M-1){1'b0}}, 1'b1};

    logic         sign_a;
    logic         sign_b;
    logic [M-2:0] mag_a;
    logic [M-2:0] mag_b;
    logic         illegal;
    logic         lt;

    assign sign_a  = a[M-1];
    assign sign_b  = b[M-1];
    assign mag_a   = a[M-2:0];
    assign mag_b   = b[M-2:0];
    assign illegal = (op >> 2) != '0;

    // Sign-magnitude less-than; both zeros compare equal regardless of sign.
    always_comb begin
        lt = 1'b0;
        if (mag_a == '0 && mag_b == '0)
            lt = 1'b0;
        else if (sign_a != sign_b)
            lt = sign_a;
        else if (!sign_a)
            lt = (mag_a < mag_b);
        else
            lt = (mag_a > mag_b);
    end

    // Opcode decode and result selection.
    always_comb begin
        result = '0;
        error  = 1'b0;
        if (illegal) begin
            result = '0;
            error  = 1'b1;
        end else begin
            case (op_e'(op[1:0]))
                OP_SUB:   result = a - b;
                OP_SM_LT: result = {{(M-1){1'b0}}, lt};
                OP_CLR_BIT: begin
                    if (b < IDX_LIM) begin
                        result = a & ~(ONE << b);
                    end else begin
                        result = a;
                        error  = 1'b1;
                    end
                end
                OP_SM2U2: begin
                    if (!sign_a) begin
                        result = a;
                    end else if (mag_a == '0) begin
                        result = '0;
                        error  = 1'b1;
                    end else begin
                        result = '0 - {1'b0, mag_a};
                    end
                end
                default: begin
                    result = '0;
                    error  = 1'b1;
                end
            endcase
        end
    end

    // Flags describe the final result only.
    always_comb begin
        status = f_status(64'(result), M);
    end

endmodule

// File: rtl/sm_alu_pipe.sv
// Two-stage valid/ready pipeline around the SM/U2 ALU core, with a saturating error counter.
module sm_alu_pipe
    import sm_alu_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 2,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_op,
    input  logic [M-1:0]     i_argA,
    input  logic [M-1:0]     i_argB,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [M-1:0]     o_result,
    output logic [3:0]       o_status,
    output logic             o_error,
    input  logic             i_clr_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    logic             rdy_en;
    logic             vld_p1;
    logic [N-1:0]     op_p1;
    logic [M-1:0]     a_p1;
    logic [M-1:0]     b_p1;
    logic             vld_p2;
    logic [M-1:0]     res_p2;
    logic [3:0]       st_p2;
    logic             err_p2;
    logic [CNT_W-1:0] cnt;

    logic             load_p2;
    logic             accept;
    logic             deliver;
    logic [M-1:0]     unit_res;
    logic [3:0]       unit_st;
    logic             unit_err;

    assign load_p2 = !vld_p2 || i_ready;
    assign o_ready = rdy_en && (!vld_p1 || load_p2);
    assign accept  = i_valid && o_ready;
    assign deliver = vld_p2 && i_ready;

    assign o_valid   = vld_p2;
    assign o_result  = res_p2;
    assign o_status  = st_p2;
    assign o_error   = err_p2;
    assign o_err_cnt = cnt;

    sm_alu_unit #(.M(M), .N(N)) u_unit (
        .op     (op_p1),
        .a      (a_p1),
        .b      (b_p1),
        .result (unit_res),
        .status (unit_st),
        .error  (unit_err)
    );

    // Stage 1: capture accepted operands; hold while the stage is blocked.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdy_en <= 1'b0;
            vld_p1 <= 1'b0;
            op_p1  <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (o_ready)
                vld_p1 <= i_valid;
            if (accept) begin
                op_p1 <= i_op;
                a_p1  <= i_argA;
                b_p1  <= i_argB;
            end
        end
    end

    // Stage 2: register the core outputs; frozen while the consumer stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            st_p2  <= '0;
            err_p2 <= 1'b0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2 <= unit_res;
                st_p2  <= unit_st;
                err_p2 <= unit_err;
            end
        end
    end

    // Saturating count of delivered error beats; clear wins over increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt <= '0;
        else if (i_clr_cnt)
            cnt <= '0;
        else if (deliver && err_p2 && cnt != '1)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: tb/tb_sm_alu_pipe.sv
// Directed bench for sm_alu_pipe (M=4, N=2, CNT_W=8).
module tb_sm_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] i_op;
    logic [3:0] i_argA;
    logic [3:0] i_argB;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_result;
    logic [3:0] o_status;
    logic       o_error;
    logic       i_clr_cnt;
    logic [7:0] o_err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sm_alu_pipe #(.M(4), .N(2), .CNT_W(8)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_argA    (i_argA),
        .i_argB    (i_argB),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_status  (o_status),
        .o_error   (o_error),
        .i_clr_cnt (i_clr_cnt),
        .o_err_cnt (o_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat through an idle pipeline with the consumer always ready.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] er, input logic [3:0] es,
                          input logic ee);
        int lat;
        i_op = op; i_argA = a; i_argB = b; i_valid = 1'b1;
        chk({tag, "_rdy"}, o_ready, 1);
        tick();
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_res"}, o_result, er);
        chk({tag, "_st"}, o_status, es);
        chk({tag, "_err"}, o_error, ee);
        tick();
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_op = '0; i_argA = '0; i_argB = '0;
        i_ready = 1'b1; i_clr_cnt = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_status", o_status, 0);
        chk("rst_error", o_error, 0);
        chk("rst_cnt", o_err_cnt, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", o_ready, 1);

        // Directed operations
        run_op("sub_3_5",    2'd0, 4'd3,    4'd5,    4'hE,    4'b0010, 1'b0);
        run_op("sub_7_7",    2'd0, 4'd7,    4'd7,    4'h0,    4'b0101, 1'b0);
        run_op("lt_n3_p2",   2'd1, 4'b1011, 4'b0010, 4'h1,    4'b0000, 1'b0);
        run_op("lt_m0_p0",   2'd1, 4'b1000, 4'b0000, 4'h0,    4'b0101, 1'b0);
        run_op("lt_n3_n2",   2'd1, 4'b1011, 4'b1010, 4'h1,    4'b0000, 1'b0);
        run_op("lt_n2_n3",   2'd1, 4'b1010, 4'b1011, 4'h0,    4'b0101, 1'b0);
        run_op("lt_p2_p5",   2'd1, 4'b0010, 4'b0101, 4'h1,    4'b0000, 1'b0);
        run_op("clr_f_2",    2'd2, 4'hF,    4'd2,    4'hB,    4'b0010, 1'b0);
        chk("cnt_before", o_err_cnt, 0);
        run_op("clr_f_5",    2'd2, 4'hF,    4'd5,    4'hF,    4'b1110, 1'b1);
        chk("cnt_after", o_err_cnt, 1);
        run_op("clr_f_3",    2'd2, 4'hF,    4'd3,    4'h7,    4'b0000, 1'b0);
        run_op("u2_n3",      2'd3, 4'b1011, 4'd0,    4'b1101, 4'b0010, 1'b0);
        run_op("u2_p5",      2'd3, 4'b0101, 4'd0,    4'b0101, 4'b0100, 1'b0);
        run_op("u2_m0",      2'd3, 4'b1000, 4'd0,    4'h0,    4'b0101, 1'b1);
        chk("cnt_two", o_err_cnt, 2);

        // Backpressure: three beats offered while the consumer stalls
        i_ready = 1'b0;
        i_op = 2'd0; i_argA = 4'd7; i_argB = 4'd1; i_valid = 1'b1;
        chk("bp_rdy0", o_ready, 1);
        tick();
        i_argA = 4'd2; i_argB = 4'd1;
        chk("bp_rdy1", o_ready, 1);
        tick();
        i_argA = 4'd0; i_argB = 4'd1;
        chk("bp_rdy2", o_ready, 0);
        chk("bp_vld", o_valid, 1);
        chk("bp_res_a", o_result, 4'h6);
        repeat (3) tick();
        chk("bp_rdy_hold", o_ready, 0);
        chk("bp_vld_hold", o_valid, 1);
        chk("bp_res_hold", o_result, 4'h6);
        chk("bp_st_hold", o_status, 4'b0100);
        i_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", o_ready, 1);
        tick();
        i_valid = 1'b0;
        chk("bp_out1_vld", o_valid, 1);
        chk("bp_out1", o_result, 4'h1);
        tick();
        chk("bp_out2_vld", o_valid, 1);
        chk("bp_out2", o_result, 4'hF);
        tick();
        chk("bp_drained", o_valid, 0);

        // Reset while both stages are full
        i_ready = 1'b0;
        i_op = 2'd2; i_argA = 4'hF; i_argB = 4'd6; i_valid = 1'b1;
        tick();
        tick();
        i_valid = 1'b0;
        chk("full_vld", o_valid, 1);
        chk("full_rdy", o_ready, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", o_valid, 0);
        chk("mid_rst_cnt", o_err_cnt, 0);
        chk("mid_rst_rdy", o_ready, 0);
        tick();
        rst = 1'b0;
        i_ready = 1'b1;
        tick();
        chk("after_rst_vld", o_valid, 0);
        run_op("post_rst_sub", 2'd0, 4'd3, 4'd5, 4'hE, 4'b0010, 1'b0);
        chk("post_rst_cnt", o_err_cnt, 0);

        // Saturation: 260 back-to-back error beats
        i_op = 2'd2; i_argA = 4'hF; i_argB = 4'd5; i_valid = 1'b1;
        chk("sat_rdy", o_ready, 1);
        repeat (260) tick();
        i_valid = 1'b0;
        repeat (4) tick();
        chk("sat_cnt", o_err_cnt, 255);

        // Clear takes priority over an error beat delivered in the same cycle
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        chk("clr_err_vld", o_valid, 1);
        chk("clr_err_bit", o_error, 1);
        i_clr_cnt = 1'b1;
        tick();
        i_clr_cnt = 1'b0;
        chk("clr_cnt", o_err_cnt, 0);
        run_op("clr_next", 2'd3, 4'b1000, 4'd0, 4'h0, 4'b0101, 1'b1);
        chk("cnt_resume", o_err_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
